pe_act_stream_broadcaster: RTL and testbench

//   Parametrised successor to the PE broadcast controller. Streams a PE's

---
 rtl/pe_act_stream_broadcaster_pkg.sv | 26 ++
 rtl/pe_act_stream_broadcaster_skid_fifo2.sv | 41 ++++
 rtl/pe_act_stream_broadcaster.sv | 139 +++++++++++++
 tb/tb_pe_act_stream_broadcaster.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_act_stream_broadcaster_pkg.sv
// Shared definitions for the PE activation stream broadcaster: FSM states,
// done-packet flag position and the data-packet address concatenation macro.
`ifndef PE_ACT_STREAM_BROADCASTER_PKG_SV
`define PE_ACT_STREAM_BROADCASTER_PKG_SV

`define PE_ACT_DATA_ADDR(idx, pe) {1'b0, (idx), (pe)}

package pe_act_stream_broadcaster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_DONE_PKT  = 2'd2,
        ST_WAIT_COMP = 2'd3
    } state_t;

    localparam int BUF_DEPTH = 2;

    // The done flag sits above the activation-index and PE-index fields.
    function automatic int done_msb(input int act_no_w, input int pe_idx_w);
        return act_no_w + pe_idx_w;
    endfunction

endpackage

`endif

// File: rtl/pe_act_stream_broadcaster_skid_fifo2.sv
// Two-entry FIFO holding packed {addr, data} packets between the activation
// read pipeline and the router handshake; head is valid whenever count != 0.
module pe_skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pe_act_stream_broadcaster.sv
// Streams a PE's activations from its register file to the router, then sends
// the end-of-broadcast packet. Define ZERO_SKIP_EN to drop zero-valued activations.
module pe_act_stream_broadcaster
    import pe_act_stream_broadcaster_pkg::*;
#(
    parameter int PE_IDX       = 0,
    parameter int PE_IDX_WIDTH = 6,
    parameter int DATA_WIDTH   = 16,
    parameter int ACT_NO_WIDTH = 6,
    localparam int ADDR_WIDTH  = 1 + ACT_NO_WIDTH + PE_IDX_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pe_start_calc,
    input  logic [ACT_NO_WIDTH-1:0] in_act_no,
    input  logic                    comp_done,
    output logic                    in_act_read_en,
    output logic [ACT_NO_WIDTH-1:0] in_act_read_addr,
    input  logic [DATA_WIDTH-1:0]   in_act_read_data,
    output logic                    act_send_valid,
    input  logic                    router_rdy,
    output logic [DATA_WIDTH-1:0]   act_send_data,
    output logic [ADDR_WIDTH-1:0]   act_send_addr,
    output logic                    calc_done
);
    localparam int PKT_W    = ADDR_WIDTH + DATA_WIDTH;
    localparam int DONE_MSB = done_msb(ACT_NO_WIDTH, PE_IDX_WIDTH);
    localparam logic [PE_IDX_WIDTH-1:0] PE_FIELD  = PE_IDX_WIDTH'(PE_IDX);
    localparam logic [ADDR_WIDTH-1:0]   DONE_ADDR = ADDR_WIDTH'(1) << DONE_MSB;
    localparam logic [DATA_WIDTH-1:0]   DONE_DATA = DATA_WIDTH'(PE_FIELD);

    state_t                  state;
    state_t                  state_nxt;
    logic [ACT_NO_WIDTH-1:0] num_reg;
    logic [ACT_NO_WIDTH-1:0] rd_idx;
    logic                    vld_p1;
    logic [ACT_NO_WIDTH-1:0] idx_p1;
    logic [1:0]              buf_cnt;
    logic [PKT_W-1:0]        buf_head;
    logic [PKT_W-1:0]        push_pkt;
    logic                    buf_empty;
    logic                    push;
    logic                    pop;
    logic                    credit_free;

    assign buf_empty = (buf_cnt == 2'd0);
    assign pop       = !buf_empty && router_rdy;
    // A slot freed by this cycle's pop is reusable, which sustains one packet per cycle.
    assign credit_free = (buf_cnt + {1'b0, vld_p1} - {1'b0, pop}) < 2'(BUF_DEPTH);

`ifdef ZERO_SKIP_EN
    assign push = vld_p1 && (in_act_read_data != '0);
`else
    assign push = vld_p1;
`endif
    assign push_pkt = {`PE_ACT_DATA_ADDR(idx_p1, PE_FIELD), in_act_read_data};

    pe_skid_fifo2 #(.WIDTH(PKT_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_pkt),
        .count     (buf_cnt),
        .head      (buf_head)
    );

    always_comb begin
        state_nxt        = state;
        in_act_read_en   = 1'b0;
        in_act_read_addr = '0;
        act_send_valid   = 1'b0;
        act_send_data    = '0;
        act_send_addr    = '0;
        calc_done        = 1'b0;
        if (!buf_empty) begin
            act_send_valid = 1'b1;
            act_send_addr  = buf_head[PKT_W-1 -: ADDR_WIDTH];
            act_send_data  = buf_head[DATA_WIDTH-1:0];
        end
        case (state)
            ST_IDLE: begin
                // Index 0 is read alongside the start pulse to save a cycle of latency.
                if (pe_start_calc) begin
                    if (in_act_no == '0) begin
                        state_nxt = ST_DONE_PKT;
                    end else begin
                        state_nxt      = ST_STREAM;
                        in_act_read_en = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if ((rd_idx < num_reg) && credit_free) begin
                    in_act_read_en   = 1'b1;
                    in_act_read_addr = rd_idx;
                end
                if ((rd_idx == num_reg) && !vld_p1 && buf_empty) state_nxt = ST_DONE_PKT;
            end
            ST_DONE_PKT: begin
                act_send_valid = 1'b1;
                act_send_addr  = DONE_ADDR;
                act_send_data  = DONE_DATA;
                if (router_rdy) state_nxt = ST_WAIT_COMP;
            end
            ST_WAIT_COMP: begin
                if (comp_done) begin
                    calc_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            num_reg <= '0;
            rd_idx  <= '0;
            vld_p1  <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= in_act_read_en;
            if ((state == ST_IDLE) && pe_start_calc) begin
                num_reg <= in_act_no;
                rd_idx  <= ACT_NO_WIDTH'(in_act_read_en);
            end else if (in_act_read_en) begin
                rd_idx <= rd_idx + ACT_NO_WIDTH'(1);
            end
        end
    end

    // p1: index of the read whose data returns this cycle
    always_ff @(posedge clk) begin
        idx_p1 <= in_act_read_addr;
    end

endmodule

// File: tb/tb_pe_act_stream_broadcaster.sv
// Self-checking bench for pe_act_stream_broadcaster: packet-queue model plus
// literal expectations for streaming, empty bursts, stalls, zero data and reset.
module tb_pe_act_stream_broadcaster;
    localparam int PE_IDX = 5;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pe_start_calc = 1'b0;
    logic [5:0]  in_act_no = '0;
    logic        comp_done = 1'b0;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic        send_valid;
    logic        router_rdy = 1'b1;
    logic [15:0] send_data;
    logic [12:0] send_addr;
    logic        calc_done;

    pe_act_stream_broadcaster #(
        .PE_IDX       (PE_IDX),
        .PE_IDX_WIDTH (6),
        .DATA_WIDTH   (16),
        .ACT_NO_WIDTH (6)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pe_start_calc    (pe_start_calc),
        .in_act_no        (in_act_no),
        .comp_done        (comp_done),
        .in_act_read_en   (rd_en),
        .in_act_read_addr (rd_addr),
        .in_act_read_data (rd_data),
        .act_send_valid   (send_valid),
        .router_rdy       (router_rdy),
        .act_send_data    (send_data),
        .act_send_addr    (send_addr),
        .calc_done        (calc_done)
    );

    always #5 clk = ~clk;

    logic [15:0] act_mem [64];
    always @(posedge clk) if (rd_en) rd_data <= act_mem[rd_addr];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model state, owned by the monitor
    pkt_t exp_q[$];
    pkt_t log_q[$];
    int   log_cyc[$];
    pkt_t last_pkt;
    bit   busy = 0, waiting = 0, stalled = 0;
    int   cyc = 0, start_cyc = 0, act_n = 0;
    int   rd_next = 0, rd_total = 0, retired = 0, acc_data = 0;

    initial begin
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (rst) begin
                check("rst_valid", send_valid, 0);
                check("rst_rd_en", rd_en, 0);
                check("rst_calc_done", calc_done, 0);
                exp_q.delete();
                busy = 0; waiting = 0; stalled = 0;
                rd_next = 0; rd_total = 0; retired = 0; acc_data = 0;
            end else begin
                if (pe_start_calc && !busy) begin
                    busy = 1; start_cyc = cyc; act_n = int'(in_act_no);
                    rd_next = 0; rd_total = 0; retired = 0; acc_data = 0;
                    for (int i = 0; i < act_n; i++) begin
                        bit keep;
                        keep = 1;
`ifdef ZERO_SKIP_EN
                        keep = (act_mem[i] != 16'h0);
`endif
                        if (keep) exp_q.push_back({1'b0, 6'(i), 6'(PE_IDX), act_mem[i]});
                    end
                    exp_q.push_back({1'b1, 12'h000, 16'(PE_IDX)});
                end
                check("calc_done", calc_done, waiting && comp_done);
                if (waiting && comp_done) begin
                    waiting = 0;
                    busy = 0;
                end
                if (send_valid) begin
                    if (exp_q.size() == 0) begin
                        check("pkt_expected", send_valid, 0);
                    end else begin
                        check("pkt_addr", send_addr, exp_q[0].addr);
                        check("pkt_data", send_data, exp_q[0].data);
                    end
                    if (stalled) check("stall_hold", {send_addr, send_data}, last_pkt);
                    if (router_rdy) begin
                        log_q.push_back({send_addr, send_data});
                        log_cyc.push_back(cyc);
                        if (exp_q.size() > 0) begin
                            if (exp_q[0].addr[12]) waiting = 1;
                            else acc_data++;
                            void'(exp_q.pop_front());
                        end
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        last_pkt = {send_addr, send_data};
                    end
                end else begin
                    if (stalled) check("valid_held", send_valid, 1);
                    stalled = 0;
                end
                if (rd_en) begin
                    check("rd_in_burst", busy && (rd_next < act_n), 1);
                    check("rd_addr", rd_addr, rd_next);
`ifdef ZERO_SKIP_EN
                    if (act_mem[rd_addr] == 16'h0) retired++;
`endif
                    rd_next++;
                    rd_total++;
                    check("rd_credit", (rd_total - retired - acc_data) <= 2, 1);
                end
            end
        end
    end

    task automatic start_burst(input int n);
        @(negedge clk);
        pe_start_calc = 1'b1;
        in_act_no = 6'(n);
        @(negedge clk);
        pe_start_calc = 1'b0;
    endtask

    task automatic wait_done_pkt(input string name);
        int k;
        k = 0;
        while (!waiting && k < 60) begin
            @(negedge clk);
            k++;
        end
        check(name, waiting, 1);
    endtask

    task automatic pulse_comp();
        @(negedge clk);
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
        check("back_to_idle", busy, 0);
    endtask

    logic [12:0] t1_addr [5] = '{13'h0005, 13'h0045, 13'h0085, 13'h00C5, 13'h1000};
    logic [15:0] t1_data [5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0005};
    bit          rdy_tab [10] = '{1, 1, 1, 0, 0, 1, 1, 0, 1, 1};

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Four activations, router always ready; stray start and comp_done ignored.
        log_q.delete(); log_cyc.delete();
        for (int i = 0; i < 4; i++) act_mem[i] = 16'(8'h11 * (i + 1));
        start_burst(4);
        comp_done = 1'b1;
        pe_start_calc = 1'b1;
        in_act_no = 6'd9;
        @(negedge clk);
        pe_start_calc = 1'b0;
        comp_done = 1'b0;
        wait_done_pkt("t1_done_reached");
        check("t1_count", log_q.size(), 5);
        if (log_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("t1_addr_lit", log_q[i].addr, t1_addr[i]);
                check("t1_data_lit", log_q[i].data, t1_data[i]);
            end
            check("t1_latency", log_cyc[0] - start_cyc, 2);
            check("t1_back2back", log_cyc[3] - log_cyc[0], 3);
        end
        pulse_comp();

        // Empty burst: only the done packet, one cycle after start.
        log_q.delete(); log_cyc.delete();
        start_burst(0);
        wait_done_pkt("t2_done_reached");
        check("t2_count", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("t2_addr_lit", log_q[0].addr, 13'h1000);
            check("t2_data_lit", log_q[0].data, 16'h0005);
            check("t2_latency", log_cyc[0] - start_cyc, 1);
        end
        pulse_comp();

        // Router stalls mid-stream.
        log_q.delete(); log_cyc.delete();
        for (int i = 0; i < 6; i++) act_mem[i] = 16'(16'h00A0 + i);
        start_burst(6);
        for (int k = 0; k < 10; k++) begin
            router_rdy = rdy_tab[k];
            @(negedge clk);
        end
        router_rdy = 1'b1;
        wait_done_pkt("t3_done_reached");
        check("t3_count", log_q.size(), 7);
        if (log_q.size() == 7) begin
            check("t3_last_data_lit", log_q[5].data, 16'h00A5);
            check("t3_last_addr_lit", log_q[5].addr, 13'h0145);
        end
        pulse_comp();

        // Zero-valued activations.
        log_q.delete(); log_cyc.delete();
        act_mem[0] = 16'd5; act_mem[1] = 16'd0; act_mem[2] = 16'd0; act_mem[3] = 16'd7;
        start_burst(4);
        wait_done_pkt("t4_done_reached");
`ifdef ZERO_SKIP_EN
        check("t4_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("t4_second_addr_lit", log_q[1].addr, 13'h00C5);
            check("t4_second_data_lit", log_q[1].data, 16'h0007);
        end
`else
        check("t4_count", log_q.size(), 5);
        if (log_q.size() == 5) begin
            check("t4_second_addr_lit", log_q[1].addr, 13'h0045);
            check("t4_second_data_lit", log_q[1].data, 16'h0000);
        end
`endif
        pulse_comp();

        // Reset with packets buffered, then a fresh burst.
        for (int i = 0; i < 6; i++) act_mem[i] = 16'(16'h00B0 + i);
        router_rdy = 1'b0;
        start_burst(6);
        repeat (4) @(negedge clk);
        check("t5_buffered_valid", send_valid, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_valid_now", send_valid, 0);
        check("t5_rst_rd_en_now", rd_en, 0);
        @(negedge clk);
        rst = 1'b0;
        router_rdy = 1'b1;
        repeat (4) @(negedge clk);
        log_q.delete(); log_cyc.delete();
        for (int i = 0; i < 3; i++) act_mem[i] = 16'(16'h00C0 + i);
        start_burst(3);
        wait_done_pkt("t5_done_reached");
        check("t5_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("t5_first_addr_lit", log_q[0].addr, 13'h0005);
            check("t5_first_data_lit", log_q[0].data, 16'h00C0);
        end
        pulse_comp();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
